alu_mul: RTL and testbench
==========================

Name: alu_mul

Overview:
- Execute stage directly downstream of the picoMIPS register file.
- Consumes the two register read operands (Rdata1 → a; Rdata2 or decoded immediate → b) plus a function code from the decoder.
- Produces a registered result, Z/N/C flags and a one-cycle write-enable that feed back to the register file write port (Wdata1/w1).
- Add, subtract and logic ops take one cycle. Multiply ops run as a multi-cycle shift-add sequencer with a busy handshake, which the program counter uses as a stall.

Parameters:
- n, 8, data width; same as register file width; legal range 4..32.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- nReset  input  1  asynchronous, active-low reset.
- start  input  1  operation request; sampled only while busy=0.
- func  input  3  op code: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 PASSB, 101 MULL (unsigned, low n bits), 110 MULH (signed two's complement, high n bits of 2n product), 111 reserved.
- a  input  n  operand A (from register file Rdata1).
- b  input  n  operand B (register Rdata2 or immediate).
- result  output  n  registered result → register file Wdata1.
- wr_en  output  1  one-cycle pulse when result is new → register file w1.
- busy  output  1  high while a multiply is in progress; upstream must stall.
- flag_z  output  1  result == 0.
- flag_n  output  1  result[n-1].
- flag_c  output  1  ADD: carry-out; SUB: borrow (a < b unsigned); all other ops: 0.

Behaviour:
- Reset: nReset=0 asynchronously clears result=0, wr_en=0, busy=0, flags=0, FSM=IDLE, iteration counter=0, all internal operand/product registers. Reset may assert in any state, including mid-multiply; the in-flight operation is discarded and no wr_en is produced.
- FSM states: IDLE, MUL.
- Single-cycle ops (func 000–100):
  - start=1 in IDLE at edge k loads result and flags at edge k.
  - wr_en=1 for exactly the cycle after edge k; FSM stays IDLE.
  - Back-to-back starts give back-to-back wr_en pulses.
- Arithmetic:
  - ADD/SUB are n-bit modulo.
  - ADD C = bit n of a+b.
  - SUB C = 1 iff a < b unsigned.
  - PASSB: result = b.
- Multiply ops (101, 110):
  - start=1 in IDLE at edge k latches a and b (magnitudes and sign for MULH) and sets busy=1 from edge k; FSM → MUL, counter=0.
  - One shift-add iteration per edge in MUL. The n-th iteration completes at edge k+n.
  - At edge k+n: result, flags loaded; wr_en=1 for one cycle; busy=0; FSM → IDLE.
  - Latency start → wr_en is n cycles. The next start is accepted at edge k+n+1 or later.
  - MULH: sign-correct the 2n-bit product (negate if signs of a and b differ), then output bits [2n-1:n].
  - MULL: output bits [n-1:0] of the unsigned product.
  - Multiply flags: Z and N from the result; C=0.
- Inputs a, b, func may change while busy; latched copies are used.
- start while busy=1 is ignored: no effect, no queueing.
- func=111: treated as PASSB-free no-op. result and flags hold, wr_en stays 0, FSM stays IDLE.
- wr_en is never high in two consecutive cycles for a single multiply. result and flags hold their values between operations.

Test Plan:
- Reset then ADD: a=8'h7F, b=8'h01, start at edge k → result=8'h80 and wr_en=1 in cycle after edge k; N=1, Z=0, C=0.
- SUB boundaries:
  - a=5, b=5 → result=0, Z=1, C=0.
  - Next cycle, a=3, b=5 → result=8'hFE, N=1, C=1.
  - Two consecutive wr_en pulses.
- MULL a=12, b=13 (n=8) → busy high 8 cycles; result=8'h9C and a single wr_en pulse at edge k+8; C=0.
- MULH signed cases:
  - 8'h80×8'h80 → 8'h40.
  - 8'hFE×8'h03 → 8'hFF, N=1.
  - 8'h40×8'h40 → 8'h10.
- Start pulsed with func=ADD during busy, and a/b changed mid-multiply → ignored; multiply result unaffected.
- nReset asserted at iteration 4 of a MULL → all outputs 0 immediately, no wr_en. After release, a new ADD works normally.

Source files
------------

// File: rtl/alu_mul_if.sv
// Operand/result bundle between the picoMIPS decoder/register file and alu_mul.
// Latency: none; this only groups wires.
// Backpressure: busy tells upstream to stall; start is ignored while busy is high.
//
// Signals:
//   start   operation request, sampled only while busy=0
//   func    op code (ADD, SUB, AND, OR, PASSB, MULL, MULH, reserved)
//   a, b    operands (Rdata1, Rdata2 or immediate)
//   result  registered result to register file Wdata1
//   wr_en   one-cycle write pulse to register file w1
//   busy    multiply in progress
//   flag_z / flag_n / flag_c   zero, negative, carry/borrow
interface alu_mul_if #(
    parameter int n = 8
);
    logic         start;
    logic [2:0]   func;
    logic [n-1:0] a;
    logic [n-1:0] b;
    logic [n-1:0] result;
    logic         wr_en;
    logic         busy;
    logic         flag_z;
    logic         flag_n;
    logic         flag_c;

    // Upstream side: decoder / register file / PC stall logic.
    modport master (
        output start, func, a, b,
        input  result, wr_en, busy, flag_z, flag_n, flag_c
    );

    // Execute stage side.
    modport slave (
        input  start, func, a, b,
        output result, wr_en, busy, flag_z, flag_n, flag_c
    );
endinterface

// File: rtl/alu_mul.sv
// picoMIPS execute stage: ADD/SUB/AND/OR/PASSB in one cycle, MULL/MULH by shift-add sequencer.
// Latency: single-cycle ops write at the start edge; multiplies write n edges after the start edge.
// Backpressure: busy is high while a multiply runs; start is ignored (not queued) while busy.
//
// Ports:
//   clk     system clock, rising edge
//   nReset  asynchronous active-low reset; discards any in-flight multiply
//   bus     alu_mul_if.slave: start/func/a/b in, result/wr_en/busy/flags out
module alu_mul #(
    parameter int n = 8
) (
    input  logic       clk,
    input  logic       nReset,
    alu_mul_if.slave   bus
);

    localparam int CW = (n > 1) ? $clog2(n) : 1;
    localparam logic [CW-1:0] LAST_ITER = CW'(n - 1);

    localparam logic [2:0] F_ADD   = 3'b000;
    localparam logic [2:0] F_SUB   = 3'b001;
    localparam logic [2:0] F_AND   = 3'b010;
    localparam logic [2:0] F_OR    = 3'b011;
    localparam logic [2:0] F_PASSB = 3'b100;
    localparam logic [2:0] F_MULL  = 3'b101;
    localparam logic [2:0] F_MULH  = 3'b110;

    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [n-1:0]     mcand_q, mcand_d;
    logic [2*n-1:0]   prod_q, prod_d;
    logic             neg_q, neg_d;
    logic             hi_q, hi_d;
    logic [n-1:0]     result_q, result_d;
    logic             wr_en_q, wr_en_d;
    logic             zf_q, zf_d;
    logic             nf_q, nf_d;
    logic             cf_q, cf_d;

    // Single-cycle datapath. One extra bit catches ADD carry-out and SUB borrow.
    logic [n:0]       add_sum;
    logic [n:0]       sub_diff;
    logic             is_mulh;
    logic [n-1:0]     abs_a;
    logic [n-1:0]     abs_b;

    assign add_sum  = {1'b0, bus.a} + {1'b0, bus.b};
    assign sub_diff = {1'b0, bus.a} - {1'b0, bus.b};
    assign is_mulh  = (bus.func == F_MULH);
    // Magnitudes for MULH. -128 maps to 8'h80, which is the correct unsigned magnitude.
    assign abs_a    = bus.a[n-1] ? -bus.a : bus.a;
    assign abs_b    = bus.b[n-1] ? -bus.b : bus.b;

    // One shift-add step. prod_q holds {partial_sum, remaining multiplier bits};
    // the add is n+1 bits wide so its carry shifts into the top of the product.
    logic [n:0]       step_sum;
    logic [2*n-1:0]   prod_step;
    logic [2*n-1:0]   prod_fin;

    assign step_sum  = {1'b0, prod_q[2*n-1:n]} + (prod_q[0] ? {1'b0, mcand_q} : {(n+1){1'b0}});
    assign prod_step = {step_sum, prod_q[n-1:1]};
    assign prod_fin  = neg_q ? -prod_step : prod_step;

    logic             load;
    logic [n-1:0]     new_res;
    logic             new_c;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        prod_d   = prod_q;
        neg_d    = neg_q;
        hi_d     = hi_q;
        result_d = result_q;
        zf_d     = zf_q;
        nf_d     = nf_q;
        cf_d     = cf_q;
        wr_en_d  = 1'b0;
        load     = 1'b0;
        new_res  = '0;
        new_c    = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    case (bus.func)
                        F_ADD: begin
                            load    = 1'b1;
                            new_res = add_sum[n-1:0];
                            new_c   = add_sum[n];
                        end
                        F_SUB: begin
                            load    = 1'b1;
                            new_res = sub_diff[n-1:0];
                            new_c   = sub_diff[n];
                        end
                        F_AND: begin
                            load    = 1'b1;
                            new_res = bus.a & bus.b;
                        end
                        F_OR: begin
                            load    = 1'b1;
                            new_res = bus.a | bus.b;
                        end
                        F_PASSB: begin
                            load    = 1'b1;
                            new_res = bus.b;
                        end
                        F_MULL, F_MULH: begin
                            // Latch operands so upstream may change a/b/func while busy.
                            state_d = MUL;
                            cnt_d   = '0;
                            hi_d    = is_mulh;
                            neg_d   = is_mulh & (bus.a[n-1] ^ bus.b[n-1]);
                            mcand_d = is_mulh ? abs_a : bus.a;
                            prod_d  = {{n{1'b0}}, (is_mulh ? abs_b : bus.b)};
                        end
                        default: ; // reserved op: hold everything, no write
                    endcase
                end
            end

            MUL: begin
                prod_d = prod_step;
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == LAST_ITER) begin
                    // Final iteration: sign-correct and write in the same edge.
                    state_d = IDLE;
                    cnt_d   = '0;
                    load    = 1'b1;
                    new_res = hi_q ? prod_fin[2*n-1:n] : prod_fin[n-1:0];
                    new_c   = 1'b0;
                end
            end

            default: state_d = IDLE;
        endcase

        if (load) begin
            result_d = new_res;
            zf_d     = (new_res == '0);
            nf_d     = new_res[n-1];
            cf_d     = new_c;
            wr_en_d  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            mcand_q  <= '0;
            prod_q   <= '0;
            neg_q    <= 1'b0;
            hi_q     <= 1'b0;
            result_q <= '0;
            wr_en_q  <= 1'b0;
            zf_q     <= 1'b0;
            nf_q     <= 1'b0;
            cf_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            prod_q   <= prod_d;
            neg_q    <= neg_d;
            hi_q     <= hi_d;
            result_q <= result_d;
            wr_en_q  <= wr_en_d;
            zf_q     <= zf_d;
            nf_q     <= nf_d;
            cf_q     <= cf_d;
        end
    end

    assign bus.result = result_q;
    assign bus.wr_en  = wr_en_q;
    assign bus.busy   = (state_q == MUL);
    assign bus.flag_z = zf_q;
    assign bus.flag_n = nf_q;
    assign bus.flag_c = cf_q;

endmodule

// File: tb/tb_alu_mul.sv
// Directed testbench for alu_mul (n=8).
// Inputs change on the falling edge; outputs are sampled 1ns after the rising edge.
// Ends with a single summary line.
module tb_alu_mul;

    localparam int N = 8;

    logic clk;
    logic nReset;
    int   errors;
    int   checks;

    alu_mul_if #(.n(N)) bus ();

    alu_mul #(.n(N)) dut (
        .clk    (clk),
        .nReset (nReset),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Safety net: never hang.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic idle_inputs();
        bus.start = 1'b0;
        bus.func  = 3'b000;
        bus.a     = '0;
        bus.b     = '0;
    endtask

    // Drive a single-cycle op at edge k and check the state right after edge k.
    task automatic single_op(input string name, input logic [2:0] f,
                             input logic [7:0] ia, input logic [7:0] ib,
                             input logic [7:0] exp_r, input logic exp_z,
                             input logic exp_n, input logic exp_c);
        @(negedge clk);
        bus.start = 1'b1; bus.func = f; bus.a = ia; bus.b = ib;
        @(posedge clk); #1;
        checks++;
        if ({bus.wr_en, bus.result, bus.flag_z, bus.flag_n, bus.flag_c} !==
            {1'b1, exp_r, exp_z, exp_n, exp_c}) begin
            errors++;
            $display("FAIL %s: got wr_en=%b result=%h z=%b n=%b c=%b, expected wr_en=1 result=%h z=%b n=%b c=%b",
                     name, bus.wr_en, bus.result, bus.flag_z, bus.flag_n, bus.flag_c,
                     exp_r, exp_z, exp_n, exp_c);
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        nReset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({bus.result, bus.wr_en, bus.busy, bus.flag_z, bus.flag_n, bus.flag_c} !== 13'h0) begin
            errors++;
            $display("FAIL reset_state: got result=%h wr_en=%b busy=%b z=%b n=%b c=%b, expected all 0",
                     bus.result, bus.wr_en, bus.busy, bus.flag_z, bus.flag_n, bus.flag_c);
        end
        @(negedge clk);
        nReset = 1'b1;
    endtask

    task automatic test_add();
        single_op("add_7f_01", 3'b000, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        idle_inputs();
        @(posedge clk); #1;
        checks++;
        if (bus.wr_en !== 1'b0 || bus.result !== 8'h80) begin
            errors++;
            $display("FAIL add_pulse_end: got wr_en=%b result=%h, expected wr_en=0 result=80",
                     bus.wr_en, bus.result);
        end
        single_op("add_carry", 3'b000, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 1'b1);
    endtask

    // Back-to-back SUBs give two consecutive wr_en pulses.
    task automatic test_sub_back_to_back();
        single_op("sub_5_5", 3'b001, 8'd5, 8'd5, 8'h00, 1'b1, 1'b0, 1'b0);
        single_op("sub_3_5", 3'b001, 8'd3, 8'd5, 8'hFE, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        idle_inputs();
        @(posedge clk); #1;
        checks++;
        if (bus.wr_en !== 1'b0) begin
            errors++;
            $display("FAIL sub_pulse_end: got wr_en=%b, expected 0", bus.wr_en);
        end
    endtask

    task automatic test_logic();
        single_op("and", 3'b010, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1'b0);
        single_op("or",  3'b011, 8'hF0, 8'h3C, 8'hFC, 1'b0, 1'b1, 1'b0);
        single_op("passb", 3'b100, 8'hF0, 8'h3C, 8'h3C, 1'b0, 1'b0, 1'b0);
    endtask

    // Reserved op: result/flags hold at PASSB's 3C, no write, not busy.
    task automatic test_reserved();
        @(negedge clk);
        bus.start = 1'b1; bus.func = 3'b111; bus.a = 8'h11; bus.b = 8'h00;
        @(posedge clk); #1;
        checks++;
        if ({bus.wr_en, bus.busy, bus.result, bus.flag_z} !== {1'b0, 1'b0, 8'h3C, 1'b0}) begin
            errors++;
            $display("FAIL reserved_noop: got wr_en=%b busy=%b result=%h z=%b, expected wr_en=0 busy=0 result=3c z=0",
                     bus.wr_en, bus.busy, bus.result, bus.flag_z);
        end
        @(negedge clk);
        idle_inputs();
    endtask

    // Start a multiply at edge k, watch 12 edges. Expect busy after edges k..k+7,
    // exactly one wr_en right after edge k+8, then the expected result/flags.
    // With disturb set, an ADD start and new operands are driven while busy.
    task automatic run_mul(input string name, input logic [2:0] f,
                           input logic [7:0] ia, input logic [7:0] ib,
                           input logic [7:0] exp_r, input logic exp_n,
                           input logic disturb);
        int busy_cnt;
        int wr_cnt;
        int wr_pos;
        logic [7:0] got_r;
        logic [2:0] got_f;
        busy_cnt = 0; wr_cnt = 0; wr_pos = -1; got_r = '0; got_f = '0;
        @(negedge clk);
        bus.start = 1'b1; bus.func = f; bus.a = ia; bus.b = ib;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (bus.busy === 1'b1) busy_cnt++;
            if (bus.wr_en === 1'b1) begin
                wr_cnt++;
                wr_pos = i;
                got_r  = bus.result;
                got_f  = {bus.flag_z, bus.flag_n, bus.flag_c};
            end
            @(negedge clk);
            if (disturb && i < 6) begin
                bus.start = 1'b1; bus.func = 3'b000; bus.a = 8'h55 + 8'(i); bus.b = 8'hAA;
            end else begin
                idle_inputs();
            end
        end
        checks++;
        if (busy_cnt != 8) begin
            errors++;
            $display("FAIL %s_busy: got busy for %0d cycles, expected 8", name, busy_cnt);
        end
        checks++;
        if (wr_cnt != 1 || wr_pos != 8) begin
            errors++;
            $display("FAIL %s_wr_en: got %0d pulses at offset %0d, expected 1 pulse at offset 8",
                     name, wr_cnt, wr_pos);
        end
        checks++;
        if (got_r !== exp_r || got_f !== {(exp_r == 8'h00), exp_n, 1'b0}) begin
            errors++;
            $display("FAIL %s_result: got result=%h zns=%b, expected result=%h zns=%b",
                     name, got_r, got_f, exp_r, {(exp_r == 8'h00), exp_n, 1'b0});
        end
    endtask

    task automatic test_mull();
        run_mul("mull_12_13", 3'b101, 8'd12, 8'd13, 8'h9C, 1'b1, 1'b0);
    endtask

    task automatic test_mulh();
        run_mul("mulh_80_80", 3'b110, 8'h80, 8'h80, 8'h40, 1'b0, 1'b0);
        run_mul("mulh_fe_03", 3'b110, 8'hFE, 8'h03, 8'hFF, 1'b1, 1'b0);
        run_mul("mulh_40_40", 3'b110, 8'h40, 8'h40, 8'h10, 1'b0, 1'b0);
    endtask

    task automatic test_busy_ignore();
        run_mul("mull_disturbed", 3'b101, 8'd12, 8'd13, 8'h9C, 1'b1, 1'b1);
    endtask

    // Reset during the 4th iteration of a MULL; outputs clear at once and
    // no write appears afterwards. Then an ADD works.
    task automatic test_reset_mid_mul();
        int wr_cnt;
        wr_cnt = 0;
        single_op("pre_mul_add", 3'b000, 8'h20, 8'h22, 8'h42, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        bus.start = 1'b1; bus.func = 3'b101; bus.a = 8'd12; bus.b = 8'd13;
        @(posedge clk);                    // edge k
        @(negedge clk);
        idle_inputs();
        repeat (3) @(posedge clk);         // edges k+1..k+3
        @(negedge clk);
        nReset = 1'b0;
        #1;
        checks++;
        if ({bus.result, bus.wr_en, bus.busy, bus.flag_z, bus.flag_n, bus.flag_c} !== 13'h0) begin
            errors++;
            $display("FAIL reset_mid_mul: got result=%h wr_en=%b busy=%b z=%b n=%b c=%b, expected all 0",
                     bus.result, bus.wr_en, bus.busy, bus.flag_z, bus.flag_n, bus.flag_c);
        end
        @(posedge clk);
        @(negedge clk);
        nReset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (bus.wr_en === 1'b1 || bus.busy === 1'b1) wr_cnt++;
        end
        checks++;
        if (wr_cnt != 0) begin
            errors++;
            $display("FAIL reset_no_wr: got %0d cycles with wr_en/busy after reset, expected 0", wr_cnt);
        end
        single_op("post_reset_add", 3'b000, 8'd2, 8'd3, 8'h05, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        idle_inputs();
    endtask

    initial begin
        errors = 0;
        checks = 0;
        idle_inputs();
        nReset = 1'b0;
        test_reset();
        test_add();
        test_sub_back_to_back();
        test_logic();
        test_reserved();
        test_mull();
        test_mulh();
        test_busy_ignore();
        test_reset_mid_mul();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
